// File: rtl/sharpx1_ioctl_loader.sv
// Sharp X1 ROM/RAM image loader: receives ioctl download bytes and writes them to IPL, CHR or RAM.
// Holds the Z80 in reset during a session and for HOLD_CYCLES clocks after it ends.
//
// state  | meaning
// IDLE   | no session; counters, checksum and error flag hold their last values
// LOAD   | session open, waiting for an ioctl_wr byte
// STALL  | byte latched, target memory busy, source held off
// WRITE  | one-cycle write enable to the latched target
// FINISH | session over, counting down the cpu_hold extension
module sharpx1_ioctl_loader #(
  parameter int HOLD_CYCLES = 16,
  parameter int IPL_BYTES   = 4096,
  parameter int CHR_BYTES   = 2048,
  parameter int RAM_BYTES   = 65536
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        mem_busy,
  output logic        ipl_we,
  output logic        chr_we,
  output logic        ram_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, STALL, WRITE, FINISH} state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t         state_q, state_d;
  logic [7:0]     index_q, index_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           wait_q, wait_d;
  logic           ipl_we_q, ipl_we_d, chr_we_q, chr_we_d, ram_we_q, ram_we_d;
  logic [15:0]    mem_addr_q, mem_addr_d;
  logic [7:0]     mem_data_q, mem_data_d;
  logic           cpu_hold_q, cpu_hold_d;
  logic           load_done_q, load_done_d;
  logic           load_err_q, load_err_d;
  logic [16:0]    byte_count_q, byte_count_d;
  logic [7:0]     checksum_q, checksum_d;
  logic [24:0]    limit;
  logic           fire;

  always_comb begin
    case (index_q)
      8'd0:    limit = 25'(IPL_BYTES);
      8'd1:    limit = 25'(CHR_BYTES);
      default: limit = 25'(RAM_BYTES);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    hold_d       = hold_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    cpu_hold_d   = cpu_hold_q;
    load_err_d   = load_err_q;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;
    load_done_d  = 1'b0;
    ipl_we_d     = 1'b0;
    chr_we_d     = 1'b0;
    ram_we_d     = 1'b0;
    fire         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ioctl_download) begin
          state_d      = LOAD;
          index_d      = ioctl_index;
          byte_count_d = '0;
          checksum_d   = '0;
          load_err_d   = 1'b0;
          cpu_hold_d   = 1'b1;
        end
      end
      LOAD: begin
        if (ioctl_wr) begin
          if (index_q > 8'd2 || ioctl_addr >= limit) begin
            load_err_d = 1'b1;
          end else begin
            mem_addr_d = ioctl_addr[15:0];
            mem_data_d = ioctl_dout;
            state_d    = mem_busy ? STALL : WRITE;
            fire       = !mem_busy;
          end
        end else if (!ioctl_download) begin
          state_d     = FINISH;
          load_done_d = 1'b1;
          hold_d      = HOLD_LOAD;
        end
      end
      STALL: begin
        if (ioctl_wr) load_err_d = 1'b1;
        if (!mem_busy) begin
          state_d = WRITE;
          fire    = 1'b1;
        end
      end
      WRITE: begin
        if (ioctl_wr) load_err_d = 1'b1;
        if (ioctl_download) begin
          state_d = LOAD;
        end else begin
          state_d     = FINISH;
          load_done_d = 1'b1;
          hold_d      = HOLD_LOAD;
        end
      end
      FINISH: begin
        // A new session aborts the countdown; cpu_hold never drops in between.
        if (ioctl_download) begin
          state_d      = LOAD;
          index_d      = ioctl_index;
          byte_count_d = '0;
          checksum_d   = '0;
          load_err_d   = 1'b0;
        end else if (hold_q == '0) begin
          state_d    = IDLE;
          cpu_hold_d = 1'b0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Enables are registered on entry to WRITE so they are high for exactly that cycle.
    if (fire) begin
      ipl_we_d     = (index_q == 8'd0);
      chr_we_d     = (index_q == 8'd1);
      ram_we_d     = (index_q == 8'd2);
      byte_count_d = byte_count_q + 17'd1;
      checksum_d   = checksum_q + mem_data_d;
    end

    wait_d = (state_d == STALL) || (state_d == WRITE);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      index_q      <= '0;
      hold_q       <= '0;
      wait_q       <= 1'b0;
      ipl_we_q     <= 1'b0;
      chr_we_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      hold_q       <= hold_d;
      wait_q       <= wait_d;
      ipl_we_q     <= ipl_we_d;
      chr_we_q     <= chr_we_d;
      ram_we_q     <= ram_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign ipl_we     = ipl_we_q;
  assign chr_we     = chr_we_q;
  assign ram_we     = ram_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_sharpx1_ioctl_loader.sv
// Bench for sharpx1_ioctl_loader: table of single-byte sessions plus hand-written
// sequences for stall timing, aborted countdown and reset corner cases.
module tb_sharpx1_ioctl_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_busy;
  logic        ipl_we, chr_we, ram_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_hold, load_done, load_err;
  logic [16:0] byte_count;
  logic [7:0]  checksum;

  sharpx1_ioctl_loader #(.HOLD_CYCLES(16), .IPL_BYTES(4096), .CHR_BYTES(2048), .RAM_BYTES(65536)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_busy(mem_busy),
    .ipl_we(ipl_we), .chr_we(chr_we), .ram_we(ram_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  int n_ipl = 0, n_chr = 0, n_ram = 0, n_done = 0, n_multi = 0;

  always @(negedge clk_sys) begin
    n_ipl  <= n_ipl + int'(ipl_we);
    n_chr  <= n_chr + int'(chr_we);
    n_ram  <= n_ram + int'(ram_we);
    n_done <= n_done + int'(load_done);
    if (int'(ipl_we) + int'(chr_we) + int'(ram_we) > 1) n_multi <= n_multi + 1;
  end

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    int          busy;
    int          e_ipl, e_chr, e_ram;
    logic        e_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {25'd0, ioctl_wait, ipl_we, chr_we, ram_we, cpu_hold, load_done, load_err}, 32'd0);
    chk({tag, "_addr_data"}, {8'd0, mem_addr, mem_data}, 32'd0);
    chk({tag, "_count"}, {15'd0, byte_count}, 32'd0);
    chk({tag, "_checksum"}, {24'd0, checksum}, 32'd0);
  endtask

  task automatic begin_session(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int busy_n);
    int g;
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    mem_busy = (busy_n > 0);
    tick();
    ioctl_wr = 1'b0;
    if (busy_n > 1) repeat (busy_n - 1) tick();
    mem_busy = 1'b0;
    g = 0;
    while (ioctl_wait && g < 50) begin
      tick();
      g++;
    end
    if (ioctl_wait) chk("send_byte_timeout", 32'(ioctl_wait), 32'd0);
  endtask

  task automatic end_session(output int lat, output int hold);
    ioctl_download = 1'b0;
    lat = 0;
    while (!load_done && lat < 40) begin
      tick();
      lat++;
    end
    hold = -1;
    if (load_done) begin
      hold = 0;
      while (cpu_hold && hold < 100) begin
        hold++;
        tick();
      end
    end
  endtask

  initial begin
    int b_ipl, b_chr, b_ram, b_done, lat, hold, lat_bad, g;
    logic [7:0] exp_sum;

    //            idx    addr          dout   busy ipl chr ram err
    vecs[0] = '{8'd0, 25'h0000123, 8'h5A, 0,   1,  0,  0,  1'b0};
    vecs[1] = '{8'd1, 25'd2047,    8'hFF, 2,   0,  1,  0,  1'b0};
    vecs[2] = '{8'd1, 25'd2048,    8'h11, 0,   0,  0,  0,  1'b1};
    vecs[3] = '{8'd2, 25'h000FFFF, 8'h80, 3,   0,  0,  1,  1'b0};
    vecs[4] = '{8'd2, 25'h0010000, 8'h01, 0,   0,  0,  0,  1'b1};
    vecs[5] = '{8'd0, 25'd4096,    8'h02, 0,   0,  0,  0,  1'b1};
    vecs[6] = '{8'd7, 25'd0,       8'h33, 0,   0,  0,  0,  1'b1};
    vecs[7] = '{8'd3, 25'd5,       8'h44, 1,   0,  0,  0,  1'b1};
    vecs[8] = '{8'd0, 25'h1000000, 8'h55, 0,   0,  0,  0,  1'b1};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; mem_busy = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // Table of single-byte sessions
    for (int i = 0; i < 9; i++) begin
      b_ipl = n_ipl; b_chr = n_chr; b_ram = n_ram; b_done = n_done;
      begin_session(vecs[i].idx);
      chk($sformatf("v%0d_hold_start", i), 32'(cpu_hold), 32'd1);
      send_byte(vecs[i].addr, vecs[i].dout, vecs[i].busy);
      end_session(lat, hold);
      tick();
      chk($sformatf("v%0d_ipl_we", i), 32'(n_ipl - b_ipl), 32'(vecs[i].e_ipl));
      chk($sformatf("v%0d_chr_we", i), 32'(n_chr - b_chr), 32'(vecs[i].e_chr));
      chk($sformatf("v%0d_ram_we", i), 32'(n_ram - b_ram), 32'(vecs[i].e_ram));
      exp_sum = (vecs[i].e_ipl + vecs[i].e_chr + vecs[i].e_ram > 0) ? vecs[i].dout : 8'h00;
      chk($sformatf("v%0d_count", i), 32'(byte_count), 32'(vecs[i].e_ipl + vecs[i].e_chr + vecs[i].e_ram));
      chk($sformatf("v%0d_checksum", i), 32'(checksum), 32'(exp_sum));
      chk($sformatf("v%0d_err", i), 32'(load_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_done", i), 32'(n_done - b_done), 32'd1);
      chk($sformatf("v%0d_hold_len", i), 32'(hold), 32'd16);
      if (vecs[i].e_err == 1'b0)
        chk($sformatf("v%0d_mem_addr", i), {8'd0, mem_addr, mem_data}, {8'd0, vecs[i].addr[15:0], vecs[i].dout});
    end

    // Full IPL image, data = addr[7:0]
    b_ipl = n_ipl; b_done = n_done; lat_bad = 0;
    begin_session(8'd0);
    for (int a = 0; a < 4096; a++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'(a);
      tick();
      if (!ipl_we) lat_bad++;
      ioctl_wr = 1'b0;
      tick();
    end
    end_session(lat, hold);
    repeat (5) tick();
    chk("ipl_full_we", 32'(n_ipl - b_ipl), 32'd4096);
    chk("ipl_full_latency", 32'(lat_bad), 32'd0);
    chk("ipl_full_count", 32'(byte_count), 32'd4096);
    chk("ipl_full_checksum", 32'(checksum), 32'h00);
    chk("ipl_full_err", 32'(load_err), 32'd0);
    chk("ipl_full_done", 32'(n_done - b_done), 32'd1);
    chk("ipl_full_hold", 32'(hold), 32'd16);
    chk("ipl_full_cpu_hold_off", 32'(cpu_hold), 32'd0);

    // Busy for 5 cycles: wait high 6 cycles, ram_we on cycle 7
    b_ram = n_ram;
    begin_session(8'd2);
    ioctl_wr = 1'b1; ioctl_addr = 25'h1234; ioctl_dout = 8'h9E; mem_busy = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      ioctl_wr = 1'b0;
      chk($sformatf("stall5_wait_c%0d", k), 32'(ioctl_wait), 32'(k <= 7));
      chk($sformatf("stall5_ram_we_c%0d", k), 32'(ram_we), 32'(k == 7));
      if (k == 6) mem_busy = 1'b0;
    end
    end_session(lat, hold);
    tick();
    chk("stall5_single_write", 32'(n_ram - b_ram), 32'd1);
    chk("stall5_mem", {8'd0, mem_addr, mem_data}, 32'h0012349E);

    // Download falls while stalled; write still completes, then FINISH
    b_ram = n_ram;
    begin_session(8'd2);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0042; ioctl_dout = 8'h3C; mem_busy = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) tick();
    mem_busy = 1'b0;
    g = 0;
    while (!ram_we && g < 10) begin
      tick();
      g++;
    end
    chk("dl_fall_stall_we", 32'(ram_we), 32'd1);
    end_session(lat, hold);
    chk("dl_fall_stall_done_lat", 32'(lat), 32'd1);
    chk("dl_fall_stall_hold", 32'(hold), 32'd16);
    chk("dl_fall_stall_count", {15'd0, byte_count}, 32'd1);
    chk("dl_fall_stall_sum", 32'(checksum), 32'h3C);
    chk("dl_fall_stall_writes", 32'(n_ram - b_ram), 32'd1);

    // ioctl_wr repeated while stalled is ignored and flagged
    b_ram = n_ram;
    begin_session(8'd2);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0200; ioctl_dout = 8'h07; mem_busy = 1'b1;
    tick();
    tick();
    ioctl_wr = 1'b0; mem_busy = 1'b0;
    repeat (3) tick();
    end_session(lat, hold);
    tick();
    chk("wr_in_stall_writes", 32'(n_ram - b_ram), 32'd1);
    chk("wr_in_stall_err", 32'(load_err), 32'd1);
    chk("wr_in_stall_count", {15'd0, byte_count}, 32'd1);
    chk("wr_in_stall_sum", 32'(checksum), 32'h07);

    // New download during FINISH aborts the countdown
    begin_session(8'd1);
    send_byte(25'd5, 8'h10, 0);
    ioctl_download = 1'b0;
    tick();
    chk("abort_done_pulse", 32'(load_done), 32'd1);
    repeat (3) tick();
    ioctl_download = 1'b1;
    tick();
    chk("abort_reinit", {22'd0, cpu_hold, byte_count, checksum[0]}, {22'd0, 1'b1, 17'd0, 1'b0});
    send_byte(25'd6, 8'h22, 0);
    end_session(lat, hold);
    chk("abort_count", {15'd0, byte_count}, 32'd1);
    chk("abort_sum", 32'(checksum), 32'h22);
    chk("abort_hold", 32'(hold), 32'd16);

    // Reset during WRITE with pending byte 0xA5
    begin_session(8'd2);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0010; ioctl_dout = 8'hA5; mem_busy = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    reset_n = 1'b0;
    tick();
    check_zero("rst_write");
    b_ram = n_ram;
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_write_no_we", 32'(n_ram - b_ram), 32'd0);
    check_zero("rst_write_idle");

    // Reset while stalled discards the latched byte
    b_ram = n_ram;
    begin_session(8'd2);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0020; ioctl_dout = 8'h66; mem_busy = 1'b1;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; mem_busy = 1'b0;
    repeat (4) tick();
    chk("rst_stall_no_we", 32'(n_ram - b_ram), 32'd0);
    chk("rst_stall_wait", 32'(ioctl_wait), 32'd0);

    // Reset released with download already high enters LOAD next edge
    reset_n = 1'b0; ioctl_download = 1'b1; ioctl_index = 8'd0;
    repeat (2) tick();
    chk("rel_dl_in_reset", 32'(cpu_hold), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rel_dl_load", 32'(cpu_hold), 32'd1);
    send_byte(25'd1, 8'h01, 0);
    end_session(lat, hold);
    chk("rel_dl_count", {15'd0, byte_count}, 32'd1);
    chk("rel_dl_hold", 32'(hold), 32'd16);

    chk("we_exclusive", 32'(n_multi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
